// File: rtl/nibble_reg_loader_if.sv
// Bus bundle for nibble_reg_loader: beat/clear/commit/readback controls and loader outputs.
interface nibble_reg_loader_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned REG_W  = 32,
  parameter int unsigned DATA_W = 4
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic                    in_valid;
  logic [CH_W-1:0]         in_ch;
  logic [DATA_W-1:0]       in_data;
  logic                    clr_req;
  logic [NUM_CH-1:0]       clr_mask;
  logic                    commit;
  logic                    rd_start;
  logic [CH_W-1:0]         rd_ch;
  logic [NUM_CH*REG_W-1:0] regs_out;
  logic [NUM_CH-1:0]       loaded;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic                    busy;

  modport master (
    output in_valid, in_ch, in_data, clr_req, clr_mask, commit, rd_start, rd_ch,
    input  regs_out, loaded, rd_data, rd_valid, busy
  );

  modport slave (
    input  in_valid, in_ch, in_data, clr_req, clr_mask, commit, rd_start, rd_ch,
    output regs_out, loaded, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/nibble_reg_loader.sv
// Multi-channel beat-serial register loader with shadow commit and masked clear.
// Define LOADER_READBACK_EN to build the beat-serial shadow readback path.
module nibble_reg_loader #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned REG_W  = 32,
  parameter int unsigned DATA_W = 4
) (
  input logic               clk,
  input logic               rst,
  nibble_reg_loader_if.slave bus
);
  localparam int unsigned BEATS = REG_W / DATA_W;
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] BeatsC = CNT_W'(BEATS);

  logic [REG_W-1:0] sh_q  [NUM_CH];
  logic [REG_W-1:0] sh_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [REG_W-1:0] shd_q [NUM_CH];
  logic [REG_W-1:0] shd_d [NUM_CH];
  logic [NUM_CH-1:0] loaded_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign loaded_w[g]                   = (cnt_q[g] == BeatsC);
    assign bus.regs_out[g*REG_W +: REG_W] = shd_q[g];
  end
  assign bus.loaded = loaded_w;

  // Priority per channel: commit, then beat on top of it, then clear overrides both.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sh_d[i]  = sh_q[i];
      shd_d[i] = shd_q[i];
      cnt_d[i] = (bus.commit && loaded_w[i]) ? '0 : cnt_q[i];
      if (bus.commit && loaded_w[i]) begin
        shd_d[i] = sh_q[i];
      end
      if (bus.in_valid && (bus.in_ch == CH_W'(i))) begin
        sh_d[i] = REG_W'({sh_q[i], bus.in_data});
        if (cnt_d[i] != BeatsC) begin
          cnt_d[i] = cnt_d[i] + 1'b1;
        end
      end
      if (bus.clr_req && bus.clr_mask[i]) begin
        sh_d[i]  = '0;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sh_q[i]  <= '0;
        cnt_q[i] <= '0;
        shd_q[i] <= '0;
      end
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      shd_q <= shd_d;
    end
  end

`ifdef LOADER_READBACK_EN
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [REG_W-1:0] snap_q, snap_d;

  // The snapshot shifts left each beat so the current beat always sits in the top bits.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      StIdle: begin
        if (bus.rd_start && (32'(bus.rd_ch) < NUM_CH)) begin
          state_d = StRead;
          idx_d   = '0;
          snap_d  = shd_q[bus.rd_ch];
        end
      end
      StRead: begin
        snap_d = snap_q << DATA_W;
        if (idx_q == BeatsC - 1'b1) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign bus.rd_valid = (state_q == StRead);
  assign bus.busy     = (state_q == StRead);
  assign bus.rd_data  = (state_q == StRead) ? snap_q[REG_W-1 -: DATA_W] : '0;
`else
  logic unused_rd;
  assign unused_rd    = ^{bus.rd_start, bus.rd_ch};
  assign bus.rd_valid = 1'b0;
  assign bus.busy     = 1'b0;
  assign bus.rd_data  = '0;
`endif
endmodule
